// File: rtl/caesar_inverse.sv
// caesar_inverse: return-path inverse of the rotor substitution lookup.
// Scans the captured 26-entry wiring table one entry per clock. It reports
// the first index whose entry equals the captured character, with the rotor
// offset removed, as (k - offset) mod 26.
module caesar_inverse #(
    parameter int N_ENTRY = 26,
    parameter int ENTRY_W = 8
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       start,
    input  logic [N_ENTRY*ENTRY_W-1:0] table_in,
    input  logic [ENTRY_W-1:0]         char_in,
    input  logic [5:0]                 offset,
    output logic                       busy,
    output logic                       done,
    output logic                       found,
    output logic [4:0]                 idx_out
);

    typedef enum logic [1:0] {IDLE, SCAN, FIN} state_t;

    state_t r_state;
    state_t w_next;

    // Entry 0 is the most significant byte of table_in, so a [0:N-1] packed
    // view lets entry k be addressed directly as r_tbl[k].
    logic [0:N_ENTRY-1][ENTRY_W-1:0] r_tbl;
    logic [ENTRY_W-1:0]              r_char;
    logic [4:0]                      r_off;
    logic [4:0]                      r_k;
    logic                            r_bad;
    logic                            r_found;
    logic [4:0]                      r_idx;

    logic       w_accept;
    logic       w_hit;
    logic       w_last;
    logic [5:0] w_off_red;
    logic [5:0] w_diff;
    logic [5:0] w_idx;

    assign w_accept  = (r_state == IDLE) && start;
    assign w_off_red = (offset >= 6'd26) ? (offset - 6'd26) : offset;
    assign w_hit     = !r_bad && (r_tbl[r_k] == r_char);
    assign w_last    = (r_k == 5'(N_ENTRY - 1));
    // Index minus offset. A negative result shows up as bit 5 set, and adding
    // 26 brings it back into 0..25.
    assign w_diff    = {1'b0, r_k} - {1'b0, r_off};
    assign w_idx     = w_diff[5] ? (w_diff + 6'd26) : w_diff;

    // State register
    always_ff @(posedge clk) begin
        if (rst) r_state <= IDLE;
        else     r_state <= w_next;
    end

    // Next-state logic. An illegal offset still passes through SCAN for one
    // cycle. No compare happens there, and the dwell keeps its done pulse
    // in cycle 2.
    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:    if (start) w_next = SCAN;
            SCAN:    if (r_bad || w_hit || w_last) w_next = FIN;
            FIN:     w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    // Request capture, scan counter and result latch
    always_ff @(posedge clk) begin
        if (rst) begin
            r_tbl   <= '0;
            r_char  <= '0;
            r_off   <= '0;
            r_k     <= '0;
            r_bad   <= 1'b0;
            r_found <= 1'b0;
            r_idx   <= 5'h1F;
        end else if (w_accept) begin
            r_tbl  <= table_in;
            r_char <= char_in;
            r_off  <= w_off_red[4:0];
            r_k    <= '0;
            r_bad  <= (offset >= 6'd52);
            if (offset >= 6'd52) begin
                r_found <= 1'b0;
                r_idx   <= 5'h1F;
            end
        end else if (r_state == SCAN) begin
            if (w_hit) begin
                r_found <= 1'b1;
                r_idx   <= w_idx[4:0];
            end else if (r_bad || w_last) begin
                r_found <= 1'b0;
                r_idx   <= 5'h1F;
            end else begin
                r_k <= r_k + 5'd1;
            end
        end
    end

    assign busy    = (r_state == SCAN);
    assign done    = (r_state == FIN);
    assign found   = r_found;
    assign idx_out = r_idx;

endmodule

// File: doc/caesar_inverse.md
Name: caesar_inverse

Overview:
- Reverse-path companion to the forward substitution lookup of the enigma datapath.
- The forward lookup returns table entry (i + offset) mod 26.
- This block takes a character code and finds the table index whose entry equals it, then removes the rotor offset.
- It scans the 26-entry, 208-bit wiring table serially, one entry per clock, under a start/done handshake. It sits on the return path after the reflector.

Parameters:
N_ENTRY, 26, number of table entries; only 26 is supported.
ENTRY_W, 8, width of each table entry and of the character code.

Ports:
clk  input  1  single system clock; all logic on the rising edge.
rst  input  1  synchronous, active-high reset.
start  input  1  one-cycle request; sampled only in IDLE.
table_in  input  208  wiring table; entry k is table_in[207-8k -: 8], k = 0..25.
char_in  input  8  character code to locate.
offset  input  6  rotor offset, 0..51 legal.
busy  output  1  high from the cycle after start is accepted until done.
done  output  1  one-cycle pulse when a result is valid.
found  output  1  1 = match located; valid from done until the next accepted start.
idx_out  output  5  (k - offset) mod 26 on a match; 5'h1F on a miss or illegal offset.

Behaviour:
- Reset (rst=1 at a clock edge): state=IDLE, busy=0, done=0, found=0, idx_out=5'h1F. Reset overrides start and aborts any scan in progress with no done pulse.
- States: IDLE, SCAN, FIN.
- IDLE, start=1:
  - Capture table_in, char_in and offset into internal registers. Later input changes have no effect on the current search.
  - Reduce offset: if ≥26, subtract 26 once. Reduced offset is 0..25.
  - If offset ≥52, no scan: set found=0, idx_out=5'h1F, go to FIN.
  - Otherwise clear the 5-bit counter k to 0 and go to SCAN. busy=1 from the next cycle.
- SCAN, one compare per cycle (entry k against captured char):
  - Match: latch found=1 and idx_out=(k - off_r) mod 26. Compute as k - off_r, adding 26 when negative. Go to FIN.
  - No match, k=25: found=0, idx_out=5'h1F, go to FIN.
  - Otherwise k=k+1.
  - The lowest matching k wins; duplicate entries are not an error.
- FIN: done=1 for exactly one cycle, busy=0, return to IDLE. FIN ignores start.
- Latency, with the start sample edge as cycle 0:
  - Match at entry k: done high in cycle k+2.
  - Miss: done in cycle 27.
  - Illegal offset: done in cycle 2.
- Back-to-back: a start in the IDLE cycle right after FIN is accepted. Minimum throughput is one request per k+3 cycles.
- Any start while busy=1 or done=1 is dropped and has no side effect.
- found and idx_out change only when a new result is latched (after an accepted start) or on reset. They hold between requests.

Test Plan:
- Identity table (entry k = 8'h41+k, i.e. 'A'+k), char_in=8'h44, offset=0, start → done at cycle 5, found=1, idx_out=3, busy high cycles 1–4.
- Same table, char_in=8'h41, offset=30 (reduced to 4) → done at cycle 2, found=1, idx_out=22 (wrap-around).
- Same table, char_in=8'h20 → done at cycle 27, found=0, idx_out=5'h1F; then another start in the next cycle is accepted.
- Table with entries 5 and 9 both = 8'h5A, char_in=8'h5A, offset=1 → idx_out=4 (first match), done at cycle 7.
- offset=55 → done at cycle 2, found=0, idx_out=5'h1F, no scan.
- Mid-scan checks:
  - Change char_in and pulse start at cycle 3 → ignored; result matches the originally captured char.
  - Assert rst at cycle 4 → no done pulse; busy=0, idx_out=5'h1F next cycle.
